// File: rtl/lcplc_unpack_pkg.sv
// Shared constants, types and helpers for the LCPLC bit unpacker.
//   W      : stream word width (2**WORD_WIDTH_LOG)
//   BUF_W  : shift buffer width (two words)
//   CNT_W  : width of the valid-bit counter (holds 0..BUF_W)
//   REQ_W  : width of a field-length request (holds 0..W, larger saturates)
package lcplc_unpack_pkg;

    localparam int WORD_WIDTH_LOG = 5;
    localparam int W              = 1 << WORD_WIDTH_LOG;
    localparam int BUF_W          = 2 * W;
    localparam int CNT_W          = WORD_WIDTH_LOG + 2;
    localparam int REQ_W          = WORD_WIDTH_LOG + 1;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [BUF_W-1:0] buf_t;
    typedef logic [W-1:0]     word_t;

    // n-bit right-aligned mask. For n == BUF_W the shift wraps to zero and
    // the decrement yields all ones, which is exactly the full mask.
    function automatic buf_t field_mask(input cnt_t n);
        return (buf_t'(1) << n) - buf_t'(1);
    endfunction

endpackage

// File: rtl/lcplc_bit_extractor.sv
// Combinational field extractor for the LCPLC bit unpacker.
// Ports:
//   buf_data : left-aligned shift buffer; bits below the valid count are zero
//   count    : number of valid bits in buf_data
//   n        : requested field length (already saturated to W)
//   align    : discard up to the next word boundary instead of reading n bits
//   field    : extracted bits, right-aligned, zero-extended
//   consumed : number of bits removed from the buffer by this request
module lcplc_bit_extractor
    import lcplc_unpack_pkg::*;
(
    input  buf_t  buf_data,
    input  cnt_t  count,
    input  cnt_t  n,
    input  logic  align,
    output word_t field,
    output cnt_t  consumed
);

    cnt_t take;

    always_comb begin
        // Align discards count mod W bits; W is a power of two.
        take = align ? (count & cnt_t'(W - 1)) : n;

        // A short buffer only reaches here at end of image; taking the top
        // n bits of a zero-filled buffer already leaves the available bits
        // MSB-aligned within the field with zero padding below.
        consumed = (count < take) ? count : take;

        // Shift by BUF_W (take == 0) yields zero, so n = 0 returns 0.
        field = word_t'((buf_data >> (cnt_t'(BUF_W) - take)) & field_mask(take));
    end

endmodule

// File: rtl/lcplc_bit_unpacker.sv
// LCPLC decoder bit unpacker: buffers W-bit stream words and serves
// variable-length MSB-first field reads plus word-boundary align.
// Ports:
//   clk, rst                     : clock, asynchronous active-low reset
//   input_valid/ready/data/last  : word stream in (bit W-1 first)
//   req_valid/ready/bits/align   : field request (length 0..W, or align)
//   output_valid/ready/data/last : field result, one-cycle latency register
module lcplc_bit_unpacker
    import lcplc_unpack_pkg::*;
#(
    parameter int WORD_WIDTH_LOG = lcplc_unpack_pkg::WORD_WIDTH_LOG
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          input_valid,
    output logic                          input_ready,
    input  logic [(1<<WORD_WIDTH_LOG)-1:0] input_data,
    input  logic                          input_last,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [WORD_WIDTH_LOG:0]       req_bits,
    input  logic                          req_align,
    output logic                          output_valid,
    input  logic                          output_ready,
    output logic [(1<<WORD_WIDTH_LOG)-1:0] output_data,
    output logic                          output_last
);

    buf_t  buf_q, buf_d;
    cnt_t  count_q, count_d;
    logic  last_seen_q, last_seen_d;
    logic  out_valid_q, out_valid_d;
    word_t out_data_q, out_data_d;
    logic  out_last_q, out_last_d;

    cnt_t  n_eff;
    cnt_t  left;
    cnt_t  consumed, consumed_eff;
    word_t field;
    logic  out_free, can_serve, fire, accept;

    lcplc_bit_extractor u_extract (
        .buf_data (buf_q),
        .count    (count_q),
        .n        (n_eff),
        .align    (req_align),
        .field    (field),
        .consumed (consumed)
    );

    always_comb begin
        n_eff     = (req_bits > REQ_W'(W)) ? cnt_t'(W) : cnt_t'(req_bits);
        out_free  = !out_valid_q || output_ready;
        can_serve = (count_q >= n_eff) || last_seen_q || req_align;

        // Both readies are gated by rst so they drop the instant reset is
        // asserted, not just after the state flops clear.
        req_ready   = rst && out_free && can_serve;
        // Once the last word of an image is in, hold off the next image
        // until every bit of this one has been read.
        input_ready = rst && (count_q <= cnt_t'(W)) && !(last_seen_q && (count_q != '0));

        fire   = req_valid && req_ready;
        accept = input_valid && input_ready;
    end

    always_comb begin
        consumed_eff = fire ? consumed : '0;
        left         = count_q - consumed_eff;

        // Consume first, then place the new word right below what remains.
        buf_d   = buf_q << consumed_eff;
        count_d = left;
        if (accept) begin
            buf_d   = buf_d | ({input_data, {W{1'b0}}} >> left);
            count_d = left + cnt_t'(W);
        end

        last_seen_d = last_seen_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        if (fire) begin
            out_valid_d = 1'b1;
            out_data_d  = field;
            out_last_d  = last_seen_q && (left == '0);
            if (last_seen_q && (left == '0)) begin
                last_seen_d = 1'b0;
            end
        end else if (output_ready) begin
            out_valid_d = 1'b0;
        end

        // Input is blocked while last_seen is set with bits pending, so this
        // never collides with the clear above.
        if (accept && input_last) begin
            last_seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q       <= '0;
            count_q     <= '0;
            last_seen_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            count_q     <= count_d;
            last_seen_q <= last_seen_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign output_valid = out_valid_q;
    assign output_data  = out_data_q;
    assign output_last  = out_last_q;

endmodule

// File: tb/tb_lcplc_bit_unpacker.sv
module tb_lcplc_bit_unpacker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        input_valid = 1'b0;
    logic        input_ready;
    logic [31:0] input_data = '0;
    logic        input_last = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_bits = '0;
    logic        req_align = 1'b0;
    logic        output_valid;
    logic        output_ready = 1'b1;
    logic [31:0] output_data;
    logic        output_last;

    int n_cmp = 0;
    int n_bad = 0;

    lcplc_bit_unpacker dut (
        .clk          (clk),
        .rst          (rst),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .input_last   (input_last),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_bits     (req_bits),
        .req_align    (req_align),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_data  (output_data),
        .output_last  (output_last)
    );

    always #5 clk = ~clk;

    // kind: 0 = push word, 1 = field request, 2 = check buffered bit count
    typedef struct {
        int          kind;
        logic [31:0] data;
        logic        last;
        logic [5:0]  bits;
        logic        align;
        logic [31:0] exp;
        logic        exp_last;
    } step_t;

    step_t tbl[$];

    function automatic step_t sw(input logic [31:0] d, input logic l);
        step_t s;
        s = '{kind: 0, data: d, last: l, bits: 6'd0, align: 1'b0, exp: 32'd0, exp_last: 1'b0};
        return s;
    endfunction

    function automatic step_t sr(input logic [5:0] b, input logic a, input logic [31:0] e, input logic el);
        step_t s;
        s = '{kind: 1, data: 32'd0, last: 1'b0, bits: b, align: a, exp: e, exp_last: el};
        return s;
    endfunction

    function automatic step_t sc(input logic [31:0] e);
        step_t s;
        s = '{kind: 2, data: 32'd0, last: 1'b0, bits: 6'd0, align: 1'b0, exp: e, exp_last: 1'b0};
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    // All tasks start and end at posedge+1.
    task automatic push_word(input string name, input logic [31:0] d, input logic l);
        input_valid = 1'b1;
        input_data  = d;
        input_last  = l;
        for (int k = 0; k < 50 && !input_ready; k++) begin
            @(posedge clk); #1;
        end
        if (!input_ready) tmo(name);
        @(posedge clk); #1;
        input_valid = 1'b0;
        input_last  = 1'b0;
    endtask

    task automatic do_req(input string name, input logic [5:0] b, input logic a,
                          input logic [31:0] e, input logic el);
        req_valid = 1'b1;
        req_bits  = b;
        req_align = a;
        for (int k = 0; k < 50 && !req_ready; k++) begin
            @(posedge clk); #1;
        end
        if (!req_ready) tmo(name);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_align = 1'b0;
        chk({name, ".valid"}, {31'd0, output_valid}, 32'd1);
        chk({name, ".data"}, output_data, e);
        chk({name, ".last"}, {31'd0, output_last}, {31'd0, el});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // basic extraction
        tbl.push_back(sw(32'hDEADBEEF, 1'b0));
        tbl.push_back(sr(6'd4,  1'b0, 32'h0000000D, 1'b0));
        tbl.push_back(sr(6'd8,  1'b0, 32'h000000EA, 1'b0));
        tbl.push_back(sr(6'd20, 1'b0, 32'h000DBEEF, 1'b0));
        tbl.push_back(sc(32'd0));
        // straddle across two words, last-marked
        tbl.push_back(sw(32'h12345678, 1'b0));
        tbl.push_back(sw(32'h9ABCDEF0, 1'b1));
        tbl.push_back(sr(6'd28, 1'b0, 32'h01234567, 1'b0));
        tbl.push_back(sr(6'd8,  1'b0, 32'h00000089, 1'b0));
        tbl.push_back(sr(6'd28, 1'b0, 32'h0ABCDEF0, 1'b1));
        tbl.push_back(sc(32'd0));
        // align
        tbl.push_back(sw(32'hF0000000, 1'b0));
        tbl.push_back(sw(32'h00000001, 1'b1));
        tbl.push_back(sr(6'd4,  1'b0, 32'h0000000F, 1'b0));
        tbl.push_back(sr(6'd0,  1'b1, 32'h00000000, 1'b0));
        tbl.push_back(sc(32'd32));
        tbl.push_back(sr(6'd32, 1'b0, 32'h00000001, 1'b1));
        tbl.push_back(sr(6'd0,  1'b1, 32'h00000000, 1'b0));
        tbl.push_back(sc(32'd0));
        // align on an aligned, non-empty buffer consumes nothing
        tbl.push_back(sw(32'hA5A5A5A5, 1'b0));
        tbl.push_back(sr(6'd0,  1'b1, 32'h00000000, 1'b0));
        tbl.push_back(sc(32'd32));
        tbl.push_back(sr(6'd32, 1'b0, 32'hA5A5A5A5, 1'b0));
        // n = 0 and saturation of n > W
        tbl.push_back(sw(32'h87654321, 1'b0));
        tbl.push_back(sr(6'd0,  1'b0, 32'h00000000, 1'b0));
        tbl.push_back(sc(32'd32));
        tbl.push_back(sr(6'd40, 1'b0, 32'h87654321, 1'b0));
        tbl.push_back(sc(32'd0));

        // reset state, rst still asserted; req_bits = 0 would be servable
        #2;
        chk("rst.output_valid", {31'd0, output_valid}, 32'd0);
        chk("rst.output_data", output_data, 32'd0);
        chk("rst.output_last", {31'd0, output_last}, 32'd0);
        chk("rst.input_ready", {31'd0, input_ready}, 32'd0);
        chk("rst.req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            string nm;
            nm = $sformatf("step%0d", i);
            case (tbl[i].kind)
                0: push_word(nm, tbl[i].data, tbl[i].last);
                1: do_req(nm, tbl[i].bits, tbl[i].align, tbl[i].exp, tbl[i].exp_last);
                default: chk({nm, ".count"}, {25'd0, dut.count_q}, tbl[i].exp);
            endcase
        end
        @(posedge clk); #1;

        // backpressure
        push_word("bp.w0", 32'h11223344, 1'b0);
        push_word("bp.w1", 32'h55667788, 1'b0);
        output_ready = 1'b0;
        req_valid = 1'b1;
        req_bits  = 6'd8;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp.valid%0d", c), {31'd0, output_valid}, 32'd1);
            chk($sformatf("bp.data%0d", c), output_data, 32'h00000011);
            chk($sformatf("bp.req_ready%0d", c), {31'd0, req_ready}, 32'd0);
            chk($sformatf("bp.input_ready%0d", c), {31'd0, input_ready}, 32'd0);
            @(posedge clk); #1;
        end
        output_ready = 1'b1;
        #1;
        chk("bp.req_ready_rel", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp.valid_second", {31'd0, output_valid}, 32'd1);
        chk("bp.data_second", output_data, 32'h00000022);
        @(posedge clk); #1;
        chk("bp.drained", {31'd0, output_valid}, 32'd0);
        do_req("bp.r3", 6'd16, 1'b0, 32'h00003344, 1'b0);
        chk("bp.input_ready_back", {31'd0, input_ready}, 32'd1);
        do_req("bp.r4", 6'd32, 1'b0, 32'h55667788, 1'b0);

        // starvation and frame isolation
        push_word("st.w0", 32'hFFFFFFFF, 1'b1);
        input_valid = 1'b1;
        input_data  = 32'h00000000;
        input_last  = 1'b0;
        #1;
        chk("st.blocked0", {31'd0, input_ready}, 32'd0);
        do_req("st.r24", 6'd24, 1'b0, 32'h00FFFFFF, 1'b0);
        chk("st.blocked1", {31'd0, input_ready}, 32'd0);
        do_req("st.r16", 6'd16, 1'b0, 32'h0000FF00, 1'b1);
        chk("st.open", {31'd0, input_ready}, 32'd1);
        @(posedge clk); #1;
        input_valid = 1'b0;
        chk("st.count", {25'd0, dut.count_q}, 32'd32);
        do_req("st.next", 6'd32, 1'b0, 32'h00000000, 1'b0);

        // reset mid-stream
        push_word("rs.w0", 32'h12345678, 1'b0);
        output_ready = 1'b0;
        do_req("rs.r12", 6'd12, 1'b0, 32'h00000123, 1'b0);
        chk("rs.count20", {25'd0, dut.count_q}, 32'd20);
        req_bits = 6'd0;
        #2;
        rst = 1'b0;
        #1;
        chk("rs.output_valid", {31'd0, output_valid}, 32'd0);
        chk("rs.output_data", output_data, 32'd0);
        chk("rs.output_last", {31'd0, output_last}, 32'd0);
        chk("rs.input_ready", {31'd0, input_ready}, 32'd0);
        chk("rs.req_ready", {31'd0, req_ready}, 32'd0);
        chk("rs.count", {25'd0, dut.count_q}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        output_ready = 1'b1;
        @(posedge clk); #1;
        push_word("rs.w1", 32'hCAFEF00D, 1'b0);
        do_req("rs.hi", 6'd16, 1'b0, 32'h0000CAFE, 1'b0);
        do_req("rs.lo", 6'd16, 1'b0, 32'h0000F00D, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lcplc_bit_unpacker.md
Name: lcplc_bit_unpacker

Overview:
- Decoder-side front end for the LCPLC output bitstream. It accepts the 2**WORD_WIDTH_LOG-bit AXI-stream words that the LCPLC coder emits, buffers them, and serves variable-length bit-field read requests MSB-first, so it is the inverse of the coder's final bit packer.
- Downstream decoder stages (Golomb/exp-Golomb field parsers) issue one request per field.
- It also provides an align operation that skips to the next word boundary at slice ends.

Parameters:
- WORD_WIDTH_LOG, 5: log2 of stream word width W (W = 32).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous reset, active-low.
- input_valid  in  1  word stream valid.
- input_ready  out  1  word stream ready.
- input_data  in  W  packed word; the first bit in stream order is bit W-1.
- input_last  in  1  marks the final word of an image.
- req_valid  in  1  field request valid.
- req_ready  out  1  field request accepted.
- req_bits  in  WORD_WIDTH_LOG+1  field length n, 0..W; values above W saturate to W.
- req_align  in  1  when 1, req_bits is ignored and bits are discarded up to the next word boundary.
- output_valid  out  1  field result valid.
- output_ready  in  1  field result ready.
- output_data  out  W  extracted field, right-aligned and zero-extended.
- output_last  out  1  this field consumed the final bit of a last-marked image.

Behaviour:
- Reset (rst=0, async):
  - buffer and count cleared; last_seen=0.
  - input_ready=0, req_ready=0, output_valid=0, output_data=0, output_last=0.
  - Outputs take these values immediately, mid-transfer included; any partial image is dropped.
- Storage:
  - 2W-bit shift buffer, left-aligned.
  - count holds valid bits, 0..2W.
  - last_seen flag is set when a word with input_last=1 is accepted.
- Input side:
  - input_ready = (count <= W) && !(last_seen && count > 0).
  - On input handshake, the word is appended directly below the current valid bits.
  - Frame isolation: no word of the next image enters until the last image is fully drained.
- Request service:
  - out_free = !output_valid || output_ready.
  - A request fires when req_valid && out_free && (count >= n_eff || last_seen || req_align).
  - req_ready = out_free && (count >= n_eff || last_seen || req_align). This is combinational from req_valid-independent state plus req_bits/req_align; it never depends on output_ready through a loop.
  - Normal read:
    - output_data = top n bits of the buffer, right-aligned; count -= n.
    - n = 0 gives output_data = 0 with count unchanged.
  - Starvation at end of image (last_seen && count < n):
    - available bits are returned MSB-aligned within the n-bit field, zero-padded below.
    - count goes to 0.
  - Align:
    - d = count mod W (0 if already aligned) bits are discarded.
    - output_data = the discarded bits, right-aligned.
- Output:
  - output register, latency 1: the request fires in cycle t, and output_valid=1 from t+1.
  - Data is held stable while output_valid && !output_ready.
  - output_last = 1 when last_seen and the fire leaves count = 0; last_seen then clears.
- Simultaneous input accept and request fire in the same cycle:
  - count_next = count - consumed + W. This always stays ≤ 2W because input acceptance requires count ≤ W.
  - The shift for consumption is applied before the incoming word is placed.
- Throughput: one field per cycle sustained while count ≥ n; one word per cycle sustained while fields total ≥ W per cycle.
- Arithmetic: count is WORD_WIDTH_LOG+2 bits wide; the shifter and mask logic are 2W bits wide.

Decomposition:
- Package lcplc_unpack_pkg holds:
  - localparams W and BUF_W = 2W.
  - the count width.
  - a function that returns the n-bit right-aligned mask.
- One combinational sub-module, lcplc_bit_extractor. It takes (buffer, count, n, align) and returns (field, consumed). It is separately unit-testable.
- The top module holds the buffer, count, last_seen, handshakes and the output register.

Test Plan:
- Basic extraction: word 0xDEADBEEF (last=0), requests 4, 8, 20 → outputs 0xD, 0xEA, 0xDBEEF; count=0 afterwards; output_last=0 on all three.
- Straddle words: words 0x12345678, then 0x9ABCDEF0 with last=1; requests 28, 8, 28 → outputs 0x1234567, 0x89, 0xABCDEF0; output_last=1 on the third beat only.
- Align: words 0xF0000000, then 0x00000001 with last=1; requests 4, align, 32 → outputs 0xF, then 0x0000000 (28 bits discarded), then 0x00000001 with output_last=1. A second align on an aligned buffer → output 0, no consumption.
- Backpressure: output_ready held low for 5 cycles after the first result.
  - output_data and output_valid stay stable and req_ready stays low during those cycles.
  - input_ready follows count (low once count > W).
  - No result is lost or duplicated after release.
- Starvation and frame isolation: word 0xFFFFFFFF with last=1, then word 0x00000000 offered.
  - Requests 24, 16 → outputs 0xFFFFFF, then 0xFF00 with output_last=1.
  - input_ready stays 0 until that beat completes, then accepts the next word.
- Reset mid-stream: assert rst=0 asynchronously between clock edges while output_valid=1 and count=20.
  - All outputs clear immediately.
  - After release, word 0xCAFEF00D followed by request 16 → output 0xCAFE; no stale bits appear.
